// File: rtl/mem_port_arbiter_if.sv
// Bundle between the memory-port arbiter and its CPU, camera and memory.
// The arbiter takes the master modport; the surrounding system takes slave.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              cam_valid;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_wdata;
    logic              cam_last;
    logic              cam_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              frame_done;
    logic [15:0]       cam_words;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cam_valid, cam_addr, cam_wdata, cam_last,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, cam_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output frame_done, cam_words
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cam_valid, cam_addr, cam_wdata, cam_last,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, cam_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  frame_done, cam_words
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by the CPU data port and a camera writer.
// CPU normally wins; a camera that has waited AGE_MAX cycles wins instead.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int AGE_MAX = 7
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.master bus
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [2:0] AGE_SAT = 3'(AGE_MAX);

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_age;
    logic [15:0]       r_words;
    logic              r_frame_done;
    logic [DATA_W-1:0] r_rdata;
    logic              w_cam_win;
    logic              w_cpu_win;

    // No grant is possible while reset is held low.
    always_comb begin
        w_cam_win = 1'b0;
        w_cpu_win = 1'b0;
        if (reset && r_state == IDLE) begin
            w_cam_win = bus.cam_valid &&
                        (!bus.cpu_req || r_age == AGE_SAT);
            w_cpu_win = bus.cpu_req && !w_cam_win;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.cam_ready = 1'b0;
        bus.cpu_stall = bus.cpu_req;
        bus.cpu_rdata = r_rdata;
        unique case (1'b1)
            (r_state == RD_WAIT): begin
                bus.cpu_rdata = bus.mem_rdata;
                bus.cpu_stall = 1'b0;
                w_next        = IDLE;
            end
            w_cam_win: begin
                bus.cam_ready = 1'b1;
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.cam_addr;
                bus.mem_wdata = bus.cam_wdata;
            end
            w_cpu_win: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.cpu_addr;
                if (bus.cpu_we) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = bus.cpu_wdata;
                    bus.cpu_stall = 1'b0;
                end else begin
                    bus.cpu_stall = 1'b1;
                    w_next        = RD_WAIT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_age        <= '0;
            r_words      <= '0;
            r_frame_done <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_next;
            if (!bus.cam_valid || w_cam_win)
                r_age <= '0;
            else if (r_age < AGE_SAT)
                r_age <= r_age + 3'd1;
            if (r_state == RD_WAIT)
                r_rdata <= bus.mem_rdata;
            r_frame_done <= w_cam_win && bus.cam_last;
            if (w_cam_win)
                r_words <= bus.cam_last ? 16'd0 : r_words + 16'd1;
        end
    end

    assign bus.frame_done = r_frame_done;
    assign bus.cam_words  = r_words;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences
// and random traffic compared against a rule-level reference model.
module tb_mem_port_arbiter;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int AGE_MAX = 7;

    typedef struct packed {
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        cam_valid;
        logic [31:0] cam_addr;
        logic [31:0] cam_wdata;
        logic        cam_last;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic        stall;
        logic        ready;
        logic [31:0] rdata;
        logic [15:0] words;
        logic        fd;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_port_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .AGE_MAX(AGE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Environment memory: 16 words, synchronous read.
    logic [31:0] env_mem [16] = '{0: 32'hDEADBEEF, default: 32'h0};

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we)
                env_mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
            else
                bus.mem_rdata <= env_mem[bus.mem_addr[5:2]];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ref_mem [16] = '{0: 32'hDEADBEEF, default: 32'h0};
    bit          m_wait;
    int          m_rd_idx;
    int          m_age;
    int          m_words;
    bit          m_fd;
    logic [31:0] m_rdata;
    bit          m_cpu_done;
    bit          m_cam_acc;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait  = 1'b0;
        m_age   = 0;
        m_words = 0;
        m_fd    = 1'b0;
        m_rdata = 32'h0;
    endtask

    function automatic stim_t st(bit rq, bit we, logic [31:0] a,
                                 logic [31:0] d, bit cv,
                                 logic [31:0] ca, logic [31:0] cd,
                                 bit cl);
        stim_t s;
        s.cpu_req   = rq;
        s.cpu_we    = we;
        s.cpu_addr  = a;
        s.cpu_wdata = d;
        s.cam_valid = cv;
        s.cam_addr  = ca;
        s.cam_wdata = cd;
        s.cam_last  = cl;
        return s;
    endfunction

    task automatic drive(stim_t s);
        bus.cpu_req   = s.cpu_req;
        bus.cpu_we    = s.cpu_we;
        bus.cpu_addr  = s.cpu_addr;
        bus.cpu_wdata = s.cpu_wdata;
        bus.cam_valid = s.cam_valid;
        bus.cam_addr  = s.cam_addr;
        bus.cam_wdata = s.cam_wdata;
        bus.cam_last  = s.cam_last;
    endtask

    // Expected behaviour for one cycle, then advance the model.
    task automatic model_check();
        logic [31:0] e_en, e_we, e_ready, e_stall;
        logic [31:0] e_addr, e_wdata, e_rdata;
        bit cam_win, cpu_win;
        e_en = 0; e_we = 0; e_ready = 0;
        e_addr = 0; e_wdata = 0;
        e_stall = 32'(bus.cpu_req);
        e_rdata = m_rdata;
        cam_win = 1'b0;
        cpu_win = 1'b0;
        m_cpu_done = 1'b0;
        m_cam_acc  = 1'b0;
        if (m_wait) begin
            e_stall    = 0;
            e_rdata    = ref_mem[m_rd_idx];
            m_cpu_done = 1'b1;
        end else begin
            cam_win = bus.cam_valid &&
                      (!bus.cpu_req || m_age >= AGE_MAX);
            cpu_win = bus.cpu_req && !cam_win;
            if (cam_win) begin
                e_en = 1; e_we = 1; e_ready = 1;
                e_addr  = bus.cam_addr;
                e_wdata = bus.cam_wdata;
            end else if (cpu_win) begin
                e_en   = 1;
                e_addr = bus.cpu_addr;
                if (bus.cpu_we) begin
                    e_we = 1; e_stall = 0;
                    e_wdata = bus.cpu_wdata;
                    m_cpu_done = 1'b1;
                end else begin
                    e_stall = 1;
                end
            end
        end
        chk("mem_en", 32'(bus.mem_en), e_en);
        chk("mem_we", 32'(bus.mem_we), e_we);
        chk("mem_addr", 32'(bus.mem_addr), e_addr);
        if (!(e_en == 1 && e_we == 0))
            chk("mem_wdata", 32'(bus.mem_wdata), e_wdata);
        chk("cam_ready", 32'(bus.cam_ready), e_ready);
        chk("cpu_stall", 32'(bus.cpu_stall), e_stall);
        chk("cpu_rdata", 32'(bus.cpu_rdata), e_rdata);
        chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
        chk("cam_words", 32'(bus.cam_words), 32'(m_words));
        if (m_wait) begin
            m_rdata = e_rdata;
            m_wait  = 1'b0;
        end else if (cpu_win && !bus.cpu_we) begin
            m_wait   = 1'b1;
            m_rd_idx = int'(bus.cpu_addr[5:2]);
        end
        if (cpu_win && bus.cpu_we)
            ref_mem[bus.cpu_addr[5:2]] = bus.cpu_wdata;
        if (cam_win) begin
            ref_mem[bus.cam_addr[5:2]] = bus.cam_wdata;
            m_cam_acc = 1'b1;
            m_words   = bus.cam_last ? 0 : (m_words + 1) % 65536;
        end
        m_fd = cam_win && bus.cam_last;
        if (!bus.cam_valid || cam_win)
            m_age = 0;
        else if (m_age < AGE_MAX)
            m_age = m_age + 1;
    endtask

    // Called at posedge+1: drive, check at negedge.
    task automatic drive_check(stim_t s);
        drive(s);
        @(negedge clk);
        model_check();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(stim_t s);
        drive_check(s);
        step();
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, " mem_en"}, 32'(bus.mem_en), 32'd0);
        chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, " cam_ready"}, 32'(bus.cam_ready), 32'd0);
        chk({tag, " cpu_stall"}, 32'(bus.cpu_stall), 32'(bus.cpu_req));
        chk({tag, " cpu_rdata"}, 32'(bus.cpu_rdata), 32'd0);
        chk({tag, " cam_words"}, 32'(bus.cam_words), 32'd0);
        chk({tag, " frame_done"}, 32'(bus.frame_done), 32'd0);
    endtask

    vec_t  tbl [12];
    stim_t idle;

    initial begin
        stim_t s;
        stim_t r;
        bit    cpu_hold;
        bit    cam_hold;

        idle = st(0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = '{s: idle, en: 0, we: 0, addr: 0, stall: 0,
                    ready: 0, rdata: 0, words: 0, fd: 0};
        tbl[1]  = '{s: st(1, 0, 'h100, 0, 0, 0, 0, 0),
                    en: 1, we: 0, addr: 'h100, stall: 1,
                    ready: 0, rdata: 0, words: 0, fd: 0};
        tbl[2]  = '{s: st(1, 0, 'h100, 0, 0, 0, 0, 0),
                    en: 0, we: 0, addr: 0, stall: 0,
                    ready: 0, rdata: 'hDEADBEEF, words: 0, fd: 0};
        tbl[3]  = '{s: idle, en: 0, we: 0, addr: 0, stall: 0,
                    ready: 0, rdata: 'hDEADBEEF, words: 0, fd: 0};
        tbl[4]  = '{s: st(1, 1, 'h20, 'h55, 1, 'h4, 'hA1, 0),
                    en: 1, we: 1, addr: 'h20, stall: 0,
                    ready: 0, rdata: 'hDEADBEEF, words: 0, fd: 0};
        tbl[5]  = '{s: st(0, 0, 0, 0, 1, 'h4, 'hA1, 0),
                    en: 1, we: 1, addr: 'h4, stall: 0,
                    ready: 1, rdata: 'hDEADBEEF, words: 0, fd: 0};
        tbl[6]  = '{s: st(0, 0, 0, 0, 1, 'h8, 'hA2, 0),
                    en: 1, we: 1, addr: 'h8, stall: 0,
                    ready: 1, rdata: 'hDEADBEEF, words: 1, fd: 0};
        tbl[7]  = '{s: st(0, 0, 0, 0, 1, 'hC, 'hA3, 1),
                    en: 1, we: 1, addr: 'hC, stall: 0,
                    ready: 1, rdata: 'hDEADBEEF, words: 2, fd: 0};
        tbl[8]  = '{s: idle, en: 0, we: 0, addr: 0, stall: 0,
                    ready: 0, rdata: 'hDEADBEEF, words: 0, fd: 1};
        tbl[9]  = '{s: idle, en: 0, we: 0, addr: 0, stall: 0,
                    ready: 0, rdata: 'hDEADBEEF, words: 0, fd: 0};
        tbl[10] = '{s: st(1, 0, 'h20, 0, 0, 0, 0, 0),
                    en: 1, we: 0, addr: 'h20, stall: 1,
                    ready: 0, rdata: 'hDEADBEEF, words: 0, fd: 0};
        tbl[11] = '{s: st(1, 0, 'h20, 0, 0, 0, 0, 0),
                    en: 0, we: 0, addr: 0, stall: 0,
                    ready: 0, rdata: 'h55, words: 0, fd: 0};

        // Reset state, with a CPU request pending to see stall follow it
        s = idle;
        s.cpu_req = 1'b1;
        s.cam_valid = 1'b1;
        drive(s);
        #12;
        chk_reset_outputs("reset");
        drive(idle);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            drive_check(tbl[i].s);
            chk($sformatf("vec%0d mem_en", i), 32'(bus.mem_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d mem_we", i), 32'(bus.mem_we), 32'(tbl[i].we));
            chk($sformatf("vec%0d mem_addr", i), 32'(bus.mem_addr), tbl[i].addr);
            chk($sformatf("vec%0d cpu_stall", i), 32'(bus.cpu_stall), 32'(tbl[i].stall));
            chk($sformatf("vec%0d cam_ready", i), 32'(bus.cam_ready), 32'(tbl[i].ready));
            chk($sformatf("vec%0d cpu_rdata", i), 32'(bus.cpu_rdata), tbl[i].rdata);
            chk($sformatf("vec%0d cam_words", i), 32'(bus.cam_words), 32'(tbl[i].words));
            chk($sformatf("vec%0d frame_done", i), 32'(bus.frame_done), 32'(tbl[i].fd));
            step();
        end

        // Camera starvation limit under back-to-back CPU writes
        run(idle);
        for (int k = 1; k <= 9; k++) begin
            s = st(1, 1, 'h30, 32'h1000 + 32'(k < 9 ? k : 8),
                   k <= 8, 'h3C, 'hCAFE, 0);
            drive_check(s);
            chk($sformatf("age cyc%0d cam_ready", k),
                32'(bus.cam_ready), 32'(k == 8));
            chk($sformatf("age cyc%0d cpu_stall", k),
                32'(bus.cpu_stall), 32'(k == 8));
            step();
        end
        run(idle);

        // Reset in the middle of a read wait, then reissue
        s = st(1, 0, 'h100, 0, 0, 0, 0, 0);
        run(s);
        drive(s);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("rdwait_reset");
        model_reset();
        @(posedge clk);
        #1;
        chk("rdwait_reset held stall", 32'(bus.cpu_stall), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_check(s);
        chk("reissue stall", 32'(bus.cpu_stall), 32'd1);
        chk("reissue mem_en", 32'(bus.mem_en), 32'd1);
        step();
        drive_check(s);
        chk("reissue stall done", 32'(bus.cpu_stall), 32'd0);
        chk("reissue rdata", 32'(bus.cpu_rdata), ref_mem[0]);
        step();
        run(idle);

        // cam_words wraps after 65536 words without cam_last
        for (int i = 0; i < 65536; i++) begin
            s = st(0, 0, 0, 0, 1, 32'(i % 16) << 2, 32'(i), 0);
            drive_check(s);
            if (i == 65535)
                chk("wrap pre cam_words", 32'(bus.cam_words), 32'hFFFF);
            step();
        end
        drive_check(idle);
        chk("wrap cam_words", 32'(bus.cam_words), 32'd0);
        chk("wrap frame_done", 32'(bus.frame_done), 32'd0);
        step();

        // Random traffic honouring the hold-until-accepted rules
        r = idle;
        cpu_hold = 1'b0;
        cam_hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!cpu_hold) begin
                r.cpu_req   = $urandom_range(0, 9) < 8;
                r.cpu_we    = 1'($urandom % 2);
                r.cpu_addr  = 32'($urandom_range(0, 15)) << 2;
                r.cpu_wdata = $urandom;
            end
            if (!cam_hold) begin
                r.cam_valid = ($urandom % 3) != 0;
                r.cam_addr  = 32'($urandom_range(0, 15)) << 2;
                r.cam_wdata = $urandom;
                r.cam_last  = ($urandom % 8) == 0;
            end
            run(r);
            cpu_hold = r.cpu_req && !m_cpu_done;
            cam_hold = r.cam_valid && !m_cam_acc;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory data width.
REQ-002 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-003 SHALL have parameter AGE_MAX, default 7, number of camera wait cycles after which the camera beats the CPU.
REQ-004 SHALL have ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU data-port access request (execute/memory stage).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address (ALU result).
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  CPU load data.
- cpu_stall  out  1  CPU pipeline stall request.
- cam_valid  in  1  camera pixel-word write pending.
- cam_addr  in  ADDR_W  camera write address.
- cam_wdata  in  DATA_W  camera write data.
- cam_last  in  1  word is last of frame.
- cam_ready  out  1  camera handshake accept.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after a read strobe.
- frame_done  out  1  one-cycle pulse after the cam_last word is written.
- cam_words  out  16  count of camera words accepted in the current frame.

Function
REQ-005 SHALL implement FSM states IDLE and RD_WAIT; memory-port outputs are combinational from state, winner and inputs.
REQ-006 In IDLE, the winner SHALL be the camera if cam_valid && (!cpu_req || age == AGE_MAX); otherwise the CPU if cpu_req; otherwise none.
REQ-007 On a CPU write grant, the arbiter SHALL drive mem_en=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_stall=0, and stay in IDLE.
REQ-008 On a CPU read grant, the arbiter SHALL drive mem_en=1, mem_we=0, mem_addr=cpu_addr and cpu_stall=1, then go to RD_WAIT.
REQ-009 In RD_WAIT, the arbiter SHALL drive cpu_rdata=mem_rdata, cpu_stall=0, mem_en=0 and cam_ready=0, then return to IDLE.
- Read latency is 2 cycles, 1 stall cycle.
REQ-010 On a camera grant, the arbiter SHALL drive cam_ready=1, mem_en=1, mem_we=1, mem_addr=cam_addr and mem_wdata=cam_wdata.
- cpu_stall = cpu_req that cycle.
REQ-011 In every cycle with cpu_req=1 and no CPU completion, cpu_stall SHALL be 1.
- The CPU holds its request stable while stalled.
- The camera holds valid/addr/data until cam_ready.
REQ-012 Outside RD_WAIT, cpu_rdata SHALL be held at its last registered value.
REQ-013 age SHALL be a 3-bit register with the following behaviour:
- Increments each cycle cam_valid=1 and the camera is not granted.
- Saturates at AGE_MAX.
- Clears on a camera grant or when cam_valid=0.
- Also increments during RD_WAIT.
REQ-014 cam_words SHALL increment by 1 on each accepted camera word, wrapping from 0xFFFF to 0.
REQ-015 When cam_last is accepted, cam_words SHALL clear to 0 and frame_done SHALL pulse high the next cycle for exactly one cycle.
REQ-016 With no winner, the arbiter SHALL drive mem_en=0, mem_we=0, cam_ready=0 and cpu_stall=0.
REQ-017 mem_addr and mem_wdata SHALL be 0 when mem_en=0.
REQ-018 When cpu_req and cam_valid are both 1 with age < AGE_MAX, the CPU SHALL win.
- A CPU read followed by RD_WAIT blocks the camera 2 cycles.

Reset
REQ-019 While reset=0, regardless of clk, the arbiter SHALL hold the following:
- state = IDLE, age = 0, cam_words = 0, frame_done = 0, cpu_rdata = 0.
- mem_en = 0, mem_we = 0, cam_ready = 0.
- cpu_stall = cpu_req.
REQ-020 A reset asserted in RD_WAIT SHALL abort the read; after release the CPU read SHALL be re-arbitrated from IDLE.
- cpu_stall stays 1 until the read completes.
REQ-021 Grants SHALL start on the first rising clk edge after reset deasserts.

Verification
REQ-022 CPU read, addr 0x100, memory returns 0xDEADBEEF -> cycle 0: mem_en=1, mem_we=0, cpu_stall=1; cycle 1: cpu_rdata=0xDEADBEEF, cpu_stall=0.
REQ-023 CPU write 0x55 to 0x20 concurrent with cam_valid, age=0 -> CPU written the same cycle, cam_ready=0, age=1; camera written the next cycle if cpu_req drops.
REQ-024 cpu_req held continuously (back-to-back writes) with cam_valid=1 -> after 7 camera-losing cycles the camera wins on cycle 8, cpu_stall=1 that cycle, age clears to 0.
REQ-025 Camera writes 3 words, third with cam_last=1 -> cam_words 1, 2, then 0; frame_done high exactly one cycle after the third accept.
REQ-026 reset=0 asserted mid-RD_WAIT -> outputs immediately at reset values; after release, the read reissues and completes with 1 stall cycle.
REQ-027 65536 camera words accepted without cam_last -> cam_words wraps to 0 and frame_done stays 0.
